// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's SRAM-like instruction and data ports onto one AXI4 master
// issuing single-beat transfers, with independent read and write engines.
//
// state  | meaning
// R_IDLE | no read in flight, may accept an inst or data read
// R_AR   | arvalid asserted, waiting for arready
// R_R    | rready asserted, waiting for the single read beat
// W_IDLE | no write in flight, may accept a data write
// W_REQ  | aw and w channels outstanding, each dropped after its handshake
// W_B    | bready asserted, waiting for the write response
module sram_axi_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

  r_state_t r_state;
  w_state_t w_state;
  logic     inst_busy, data_busy;
  logic     aw_done, w_done;
  logic     inst_free, data_free;
  logic     data_rd_ok, data_wr_ok;
  logic     r_hs, b_hs, aw_hs, w_hs;

  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'd0;
  assign awlock  = 2'd0;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;
  assign awid    = 4'd1;
  assign wid     = 4'd1;
  assign wlast   = 1'b1;

  // A port frees up in the very cycle its data_ok pulse is visible.
  assign inst_free = !inst_busy || inst_data_ok;
  assign data_free = !data_busy || data_data_ok;

  assign data_rd_ok   = data_req && !data_wr && data_free && (r_state == R_IDLE);
  assign data_wr_ok   = data_req &&  data_wr && data_free && (w_state == W_IDLE);
  assign data_addr_ok = data_rd_ok || data_wr_ok;
  assign inst_addr_ok = inst_req && inst_free && (r_state == R_IDLE) && !data_rd_ok;

  assign r_hs  = rvalid && rready;
  assign b_hs  = bvalid && bready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      arid    <= 4'd0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
    end else begin
      case (r_state)
        R_IDLE: if (data_rd_ok || inst_addr_ok) begin
          r_state <= R_AR;
          arvalid <= 1'b1;
          arid    <= data_rd_ok ? 4'd1 : 4'd0;
          araddr  <= data_rd_ok ? data_addr : inst_addr;
          arsize  <= {1'b0, data_rd_ok ? data_size : inst_size};
        end
        R_AR: if (arready) begin
          r_state <= R_R;
          arvalid <= 1'b0;
          rready  <= 1'b1;
        end
        R_R: if (rvalid) begin
          r_state <= R_IDLE;
          rready  <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      awaddr  <= 32'd0;
      awsize  <= 3'd0;
      wstrb   <= 4'd0;
      wdata   <= 32'd0;
    end else begin
      case (w_state)
        W_IDLE: if (data_wr_ok) begin
          w_state <= W_REQ;
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          awaddr  <= data_addr;
          awsize  <= {1'b0, data_size};
          wstrb   <= data_wstrb;
          wdata   <= data_wdata;
        end
        W_REQ: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // Both channels may complete in the same cycle, in either order.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            w_state <= W_B;
            bready  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        W_B: if (bvalid) begin
          w_state <= W_IDLE;
          bready  <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
      inst_busy    <= 1'b0;
      data_busy    <= 1'b0;
    end else begin
      inst_data_ok <= r_hs && (rid == 4'd0);
      data_data_ok <= (r_hs && (rid != 4'd0)) || b_hs;
      if (r_hs && (rid == 4'd0)) inst_rdata <= rdata;
      if (r_hs && (rid != 4'd0)) data_rdata <= rdata;
      if (inst_addr_ok)      inst_busy <= 1'b1;
      else if (inst_data_ok) inst_busy <= 1'b0;
      if (data_addr_ok)      data_busy <= 1'b1;
      else if (data_data_ok) data_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed scenarios plus a randomized run against a transaction-level model of
// the CPU ports and an AXI slave with its own memory.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, rid, awid, wid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
  } rd_t;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  // Called in a cycle where arvalid is up; returns in the data_ok cycle.
  task automatic axi_read_resp(input logic [3:0] id, input logic [31:0] d);
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rid = id; rdata = d;
    tick();
    rvalid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    n_checks++; if ({arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok} !== 7'd0) begin n_fail++; $display("FAIL reset_handshakes: got %b required 0", {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}); end
    n_checks++; if ({inst_rdata, data_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", {inst_rdata, data_rdata}); end
    n_checks++; if ({arlen, awlen, arburst, awburst, awid, wid, wlast, arlock, arcache, arprot, awlock, awcache, awprot} !== {8'd0, 8'd0, 2'b01, 2'b01, 4'd1, 4'd1, 1'b1, 2'd0, 4'd0, 3'd0, 2'd0, 4'd0, 3'd0}) begin n_fail++; $display("FAIL fixed_fields: got %h", {arlen, awlen, arburst, awburst, awid, wid, wlast}); end
    reset = 0;
    inst_req = 1; data_req = 1; data_wr = 1;
    #1;
    n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b11) begin n_fail++; $display("FAIL reset_accept: got %b required 11", {inst_addr_ok, data_addr_ok}); end
    idle_inputs();
    tick();
  endtask

  task automatic test_inst_read();
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2;
    #1;
    n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL inst_addr_ok: got %b required 1", inst_addr_ok); end
    tick();
    inst_req = 0;
    n_checks++; if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'hBFC0_0000, 3'd2}) begin n_fail++; $display("FAIL inst_ar: got v=%b id=%h a=%h s=%0d", arvalid, arid, araddr, arsize); end
    arready = 1;
    tick();
    arready = 0;
    n_checks++; if ({arvalid, rready} !== 2'b01) begin n_fail++; $display("FAIL inst_rwait: got arvalid=%b rready=%b required 0 1", arvalid, rready); end
    rvalid = 1; rid = 0; rdata = 32'h3C08_0001;
    tick();
    rvalid = 0;
    n_checks++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {1'b1, 1'b0, 32'h3C08_0001}) begin n_fail++; $display("FAIL inst_data: got ok=%b dok=%b rdata=%h required 1 0 3c080001", inst_data_ok, data_data_ok, inst_rdata); end
    tick();
    n_checks++; if (inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL inst_pulse: got %b required 0", inst_data_ok); end
  endtask

  task automatic test_arbitration();
    inst_req = 1; inst_addr = 32'hBFC0_0040; inst_size = 2;
    data_req = 1; data_wr = 0; data_addr = 32'h0000_2004; data_size = 2;
    #1;
    n_checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL arb_priority: got d=%b i=%b required 1 0", data_addr_ok, inst_addr_ok); end
    tick();
    data_req = 0;
    n_checks++; if ({arid, araddr, inst_addr_ok} !== {4'd1, 32'h0000_2004, 1'b0}) begin n_fail++; $display("FAIL arb_ar: got id=%h a=%h iok=%b", arid, araddr, inst_addr_ok); end
    axi_read_resp(4'd1, 32'h5555_AAAA);
    n_checks++; if ({data_data_ok, data_rdata, inst_data_ok} !== {1'b1, 32'h5555_AAAA, 1'b0}) begin n_fail++; $display("FAIL arb_data: got ok=%b rdata=%h iok=%b", data_data_ok, data_rdata, inst_data_ok); end
    n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL arb_inst_after: got %b required 1", inst_addr_ok); end
    tick();
    inst_req = 0;
    n_checks++; if ({arid, araddr} !== {4'd0, 32'hBFC0_0040}) begin n_fail++; $display("FAIL arb_inst_ar: got id=%h a=%h", arid, araddr); end
    axi_read_resp(4'd0, 32'h0000_1111);
    n_checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h0000_1111}) begin n_fail++; $display("FAIL arb_inst_data: got ok=%b rdata=%h", inst_data_ok, inst_rdata); end
    tick();
  endtask

  task automatic test_write_order();
    data_req = 1; data_wr = 1; data_addr = 32'h1000; data_size = 2;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
    #1;
    n_checks++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got %b required 1", data_addr_ok); end
    tick();
    data_req = 0;
    n_checks++; if ({awvalid, wvalid, awaddr, awsize, wdata, wstrb} !== {2'b11, 32'h1000, 3'd2, 32'hDEAD_BEEF, 4'b0011}) begin n_fail++; $display("FAIL wr_fields: got v=%b%b a=%h s=%0d d=%h st=%b", awvalid, wvalid, awaddr, awsize, wdata, wstrb); end
    wready = 1;
    tick();
    wready = 0;
    n_checks++; if ({awvalid, wvalid} !== 2'b10) begin n_fail++; $display("FAIL wr_wdrop: got aw=%b w=%b required 1 0", awvalid, wvalid); end
    tick();
    n_checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin n_fail++; $display("FAIL wr_awhold: got aw=%b w=%b b=%b required 1 0 0", awvalid, wvalid, bready); end
    awready = 1;
    tick();
    awready = 0;
    n_checks++; if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0010) begin n_fail++; $display("FAIL wr_bwait: got aw=%b w=%b b=%b ok=%b required 0 0 1 0", awvalid, wvalid, bready, data_data_ok); end
    bvalid = 1;
    tick();
    bvalid = 0;
    n_checks++; if ({data_data_ok, bready} !== 2'b10) begin n_fail++; $display("FAIL wr_done: got ok=%b bready=%b required 1 0", data_data_ok, bready); end
    tick();
    n_checks++; if (data_data_ok !== 1'b0) begin n_fail++; $display("FAIL wr_single_pulse: got %b required 0", data_data_ok); end
  endtask

  task automatic test_concurrent();
    int refused;
    data_req = 1; data_wr = 1; data_addr = 32'h1010; data_wdata = 32'h0BAD_F00D; data_wstrb = 4'hF;
    #1;
    n_checks++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL cc_wr_accept: got %b required 1", data_addr_ok); end
    tick();
    data_req = 0; awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    inst_req = 1; inst_addr = 32'hBFC0_0010; inst_size = 2;
    data_req = 1; data_wr = 0; data_addr = 32'h2000;
    #1;
    n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL cc_accept: got i=%b d=%b required 1 0", inst_addr_ok, data_addr_ok); end
    tick();
    inst_req = 0;
    refused = 0;
    if (data_addr_ok === 1'b0) refused++;
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h1122_3344;
    if (data_addr_ok === 1'b0) refused++;
    tick();
    rvalid = 0;
    n_checks++; if ({inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, 32'h1122_3344, 1'b0}) begin n_fail++; $display("FAIL cc_inst_data: got ok=%b rdata=%h dok=%b", inst_data_ok, inst_rdata, data_data_ok); end
    for (int i = 0; i < 7; i++) begin
      if (data_addr_ok === 1'b0) refused++;
      tick();
    end
    bvalid = 1;
    #1;
    if (data_addr_ok === 1'b0) refused++;
    n_checks++; if (refused !== 10) begin n_fail++; $display("FAIL cc_refused: got %0d refusals required 10", refused); end
    tick();
    bvalid = 0;
    #1;
    n_checks++; if ({data_data_ok, data_addr_ok} !== 2'b11) begin n_fail++; $display("FAIL cc_reaccept: got ok=%b addr_ok=%b required 1 1", data_data_ok, data_addr_ok); end
    tick();
    data_req = 0;
    n_checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h2000}) begin n_fail++; $display("FAIL cc_rd_ar: got v=%b id=%h a=%h", arvalid, arid, araddr); end
    axi_read_resp(4'd1, 32'hCAFE_F00D);
    n_checks++; if ({data_data_ok, data_rdata} !== {1'b1, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL cc_rd_data: got ok=%b rdata=%h", data_data_ok, data_rdata); end
    tick();
  endtask

  task automatic test_stalled_read();
    int stable;
    inst_req = 1; inst_addr = 32'hBFC0_0124; inst_size = 1;
    tick();
    inst_req = 0;
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if ({arvalid, arid, araddr, arsize} === {1'b1, 4'd0, 32'hBFC0_0124, 3'd1}) stable++;
      tick();
    end
    n_checks++; if (stable !== 5) begin n_fail++; $display("FAIL stall_stable: got %0d stable cycles required 5", stable); end
    axi_read_resp(4'd0, 32'h2402_0005);
    n_checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h2402_0005}) begin n_fail++; $display("FAIL stall_data: got ok=%b rdata=%h", inst_data_ok, inst_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    inst_req = 1; inst_addr = 32'hBFC0_0200; inst_size = 2;
    tick();
    inst_req = 0; arready = 1;
    tick();
    arready = 0;
    n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_setup: got rready=%b required 1", rready); end
    reset = 1; rvalid = 1; rid = 0; rdata = 32'hFFFF_0000;
    tick();
    reset = 0; rvalid = 0;
    n_checks++; if ({arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok} !== 7'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %b required 0", {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}); end
    tick();
    inst_req = 1; inst_addr = 32'hBFC0_0300;
    #1;
    n_checks++; if ({inst_data_ok, inst_addr_ok} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_busy: got ok=%b addr_ok=%b required 0 1", inst_data_ok, inst_addr_ok); end
    tick();
    inst_req = 0;
    axi_read_resp(4'd0, 32'h0000_0300);
    n_checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h0000_0300}) begin n_fail++; $display("FAIL rst_mid_recover: got ok=%b rdata=%h", inst_data_ok, inst_rdata); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] dmem_ref[16];
    logic [31:0] dmem_slv[16];
    rd_t         rq[$];
    rd_t         ar_exp;
    logic        ar_pend, i_drv, d_drv, i_out, d_out, d_out_wr, stop;
    logic        aw_got, w_got, r_taken, b_taken;
    logic [31:0] i_exp, d_exp, exp_awaddr, exp_wdata, slv_wdata;
    logic [3:0]  exp_wstrb, slv_wstrb, d_idx;
    logic [2:0]  ar_size, exp_awsize;
    int          i_age, d_age, cyc, n_inst, n_data;
    for (int k = 0; k < 16; k++) begin
      dmem_ref[k] = $urandom;
      dmem_slv[k] = dmem_ref[k];
    end
    {ar_pend, i_drv, d_drv, i_out, d_out, d_out_wr, stop, aw_got, w_got, r_taken, b_taken} = '0;
    i_exp = 0; d_exp = 0; exp_awaddr = 0; exp_wdata = 0; exp_wstrb = 0; exp_awsize = 0;
    slv_wdata = 0; slv_wstrb = 0; d_idx = 0; ar_size = 0; ar_exp = '{4'd0, 32'd0};
    i_age = 0; d_age = 0; cyc = 0; n_inst = 0; n_data = 0;
    pulse_reset();
    while (!(stop && !i_drv && !d_drv && !i_out && !d_out)) begin
      cyc++;
      if (cyc == 3000) stop = 1;
      if (cyc > 3400) begin
        n_checks++; n_fail++;
        $display("FAIL rnd_drain: got i_out=%b d_out=%b after %0d cycles required idle", i_out, d_out, cyc);
        break;
      end
      if (inst_data_ok) begin
        n_checks++;
        if (!i_out) begin n_fail++; $display("FAIL rnd_inst_unexpected: got inst_data_ok=1 required 0"); end
        else if (inst_rdata !== i_exp) begin n_fail++; $display("FAIL rnd_inst_rdata: got %h required %h", inst_rdata, i_exp); end
        i_out = 0; n_inst++;
      end
      if (data_data_ok) begin
        n_checks++;
        if (!d_out) begin n_fail++; $display("FAIL rnd_data_unexpected: got data_data_ok=1 required 0"); end
        else if (!d_out_wr && data_rdata !== d_exp) begin n_fail++; $display("FAIL rnd_data_rdata: got %h required %h", data_rdata, d_exp); end
        d_out = 0; n_data++;
      end
      if (i_out && ++i_age > 100) begin n_checks++; n_fail++; $display("FAIL rnd_inst_timeout: got no inst_data_ok in %0d cycles", i_age); i_out = 0; end
      if (d_out && ++d_age > 100) begin n_checks++; n_fail++; $display("FAIL rnd_data_timeout: got no data_data_ok in %0d cycles", d_age); d_out = 0; end
      if (!i_drv) inst_req = 0;
      if (!d_drv) data_req = 0;
      if (!i_drv && !stop && $urandom_range(0, 2) == 0) begin
        i_drv = 1; inst_req = 1;
        inst_addr = 32'hBFC0_0000 + ($urandom_range(0, 255) << 2);
        inst_size = 2'($urandom_range(0, 2));
      end
      if (!d_drv && !stop && $urandom_range(0, 2) == 0) begin
        d_drv = 1; data_req = 1;
        data_wr = 1'($urandom_range(0, 1));
        d_idx = 4'($urandom_range(0, 15));
        data_addr = 32'h1000 + 32'(d_idx) * 4;
        data_size = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom_range(1, 15));
        data_wdata = $urandom;
      end
      if (r_taken) begin rvalid = 0; r_taken = 0; end
      if (b_taken) begin bvalid = 0; b_taken = 0; end
      arready = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      if (!rvalid && rq.size() > 0 && $urandom_range(0, 2) == 0) begin
        rvalid = 1; rid = rq[0].id;
        rdata = (rq[0].addr[31:12] == 20'h00001) ? dmem_slv[rq[0].addr[5:2]] : rom(rq[0].addr);
      end
      if (!bvalid && aw_got && w_got && $urandom_range(0, 2) == 0) bvalid = 1;
      #1;
      if (arvalid && arready) begin
        n_checks++;
        if (!ar_pend || {arid, araddr, arsize} !== {ar_exp.id, ar_exp.addr, ar_size}) begin n_fail++; $display("FAIL rnd_ar: got id=%h a=%h s=%0d required pend=1 id=%h a=%h s=%0d", arid, araddr, arsize, ar_exp.id, ar_exp.addr, ar_size); end
        rq.push_back('{arid, araddr});
        ar_pend = 0;
      end
      if (rvalid && rready) begin
        void'(rq.pop_front());
        r_taken = 1;
      end
      if (awvalid && awready) begin
        n_checks++;
        if ({awaddr, awsize} !== {exp_awaddr, exp_awsize}) begin n_fail++; $display("FAIL rnd_aw: got a=%h s=%0d required a=%h s=%0d", awaddr, awsize, exp_awaddr, exp_awsize); end
        aw_got = 1;
      end
      if (wvalid && wready) begin
        n_checks++;
        if ({wdata, wstrb} !== {exp_wdata, exp_wstrb}) begin n_fail++; $display("FAIL rnd_w: got d=%h st=%b required d=%h st=%b", wdata, wstrb, exp_wdata, exp_wstrb); end
        slv_wdata = wdata; slv_wstrb = wstrb;
        w_got = 1;
      end
      if (bvalid && bready) begin
        dmem_slv[exp_awaddr[5:2]] = merge(dmem_slv[exp_awaddr[5:2]], slv_wdata, slv_wstrb);
        aw_got = 0; w_got = 0; b_taken = 1;
      end
      if (inst_addr_ok && data_addr_ok && !data_wr) begin n_checks++; n_fail++; $display("FAIL rnd_priority: got inst_addr_ok=1 alongside data read accept required 0"); end
      if (data_addr_ok) begin
        n_checks++;
        if (d_out || !d_drv) begin n_fail++; $display("FAIL rnd_data_accept: got accept with outstanding=%b requesting=%b", d_out, d_drv); end
        d_out = 1; d_age = 0; d_drv = 0; d_out_wr = data_wr;
        if (data_wr) begin
          dmem_ref[d_idx] = merge(dmem_ref[d_idx], data_wdata, data_wstrb);
          exp_awaddr = data_addr; exp_awsize = {1'b0, data_size};
          exp_wdata = data_wdata; exp_wstrb = data_wstrb;
        end else begin
          d_exp = dmem_ref[d_idx];
          ar_pend = 1; ar_exp = '{4'd1, data_addr}; ar_size = {1'b0, data_size};
        end
      end
      if (inst_addr_ok) begin
        n_checks++;
        if (i_out || !i_drv || ar_pend) begin n_fail++; $display("FAIL rnd_inst_accept: got accept with outstanding=%b ar_pending=%b", i_out, ar_pend); end
        i_out = 1; i_age = 0; i_drv = 0;
        i_exp = rom(inst_addr);
        ar_pend = 1; ar_exp = '{4'd0, inst_addr}; ar_size = {1'b0, inst_size};
      end
      tick();
    end
    n_checks++;
    if (n_inst < 50 || n_data < 50) begin n_fail++; $display("FAIL rnd_progress: got %0d inst and %0d data completions required at least 50 each", n_inst, n_data); end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_inst_read();
    test_arbitration();
    test_write_order();
    test_concurrent();
    test_stalled_read();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
